// File: rtl/peterson_pkg.sv
// Shared types and helpers for the N-process filter (generalised Peterson) lock.
package peterson_pkg;

    typedef enum logic [2:0] {NCS, LVL, VIC, WAIT, CS, EXIT} loc_t;

    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) n += {31'd0, v[i]};
        return n;
    endfunction

endpackage

// File: rtl/peterson_filter_if.sv
// Scheduler-facing bundle of the filter lock: step select/pause in, per-process status out.
interface peterson_filter_if #(parameter int NPROC = 4);
    localparam int PW = $clog2(NPROC);

    logic [PW-1:0]    select;
    logic             pause;
    logic [NPROC-1:0] in_cs;
    logic [NPROC-1:0] waiting;
    logic             mutex_err;

    modport master (output select, pause, input in_cs, waiting, mutex_err);
    modport slave  (input select, pause, output in_cs, waiting, mutex_err);
endinterface

// File: rtl/peterson_filter_blocked.sv
// Wait condition of one filter level: the stepping process is the victim and some
// other process sits at or above its target level.
module filter_blocked #(
    parameter int  NPROC = 4,
    localparam int PW    = $clog2(NPROC)
) (
    input  logic [NPROC-1:0][PW-1:0] i_level,
    input  logic [PW-1:0]            i_victim_cur,
    input  logic [PW-1:0]            i_s,
    input  logic [PW-1:0]            i_cur,
    output logic                     o_blocked
);
    logic w_others;

    always_comb begin
        w_others = 1'b0;
        for (int k = 0; k < NPROC; k++)
            if (k != int'(i_s) && i_level[k] >= i_cur) w_others = 1'b1;
        o_blocked = (i_victim_cur == i_s) && w_others;
    end
endmodule

// File: rtl/peterson_filter.sv
// Filter lock: NPROC processes climb NPROC-1 victim-guarded levels, one step per clock.
// Define PETERSON_MUTEX_CHECK_EN to build the sticky mutual-exclusion checker.
module peterson_filter
    import peterson_pkg::*;
#(
    parameter int  NPROC = 4,
    localparam int PW    = $clog2(NPROC)
) (
    input logic               clock,
    input logic               reset,
    peterson_filter_if.slave  bus
);
    loc_t [NPROC-1:0]          r_pc, w_pc_nxt;
    logic [NPROC-1:0][PW-1:0]  r_cur, w_cur_nxt;
    logic [NPROC-1:0][PW-1:0]  r_level, w_level_nxt;
    logic [NPROC-1:0][PW-1:0]  r_victim, w_victim_nxt;   // entry 0 unused
    logic [NPROC-1:0]          r_in_cs, r_waiting;

    logic [PW-1:0] w_sel, w_s, w_cur, w_vic;
    logic          w_valid, w_blocked;

    assign w_sel   = bus.select;
    assign w_valid = int'(w_sel) < NPROC;
    // Out-of-range selects are clamped to a legal index only to keep lookups in bounds;
    // w_valid suppresses every update in that case.
    assign w_s     = w_valid ? w_sel : '0;
    assign w_cur   = r_cur[w_s];
    assign w_vic   = r_victim[w_cur];

    filter_blocked #(.NPROC(NPROC)) u_blocked (
        .i_level      (r_level),
        .i_victim_cur (w_vic),
        .i_s          (w_s),
        .i_cur        (w_cur),
        .o_blocked    (w_blocked)
    );

    always_comb begin
        w_pc_nxt     = r_pc;
        w_cur_nxt    = r_cur;
        w_level_nxt  = r_level;
        w_victim_nxt = r_victim;
        if (w_valid) begin
            case (r_pc[w_s])
                NCS:  if (!bus.pause) begin
                          w_pc_nxt[w_s]  = LVL;
                          w_cur_nxt[w_s] = PW'(1);
                      end
                LVL:  begin
                          w_level_nxt[w_s] = w_cur;
                          w_pc_nxt[w_s]    = VIC;
                      end
                VIC:  begin
                          w_victim_nxt[w_cur] = w_s;
                          w_pc_nxt[w_s]       = WAIT;
                      end
                WAIT: if (!w_blocked) begin
                          if (w_cur == PW'(NPROC - 1)) w_pc_nxt[w_s] = CS;
                          else begin
                              w_cur_nxt[w_s] = w_cur + PW'(1);
                              w_pc_nxt[w_s]  = LVL;
                          end
                      end
                CS:   if (!bus.pause) w_pc_nxt[w_s] = EXIT;
                EXIT: begin
                          w_level_nxt[w_s] = '0;
                          w_cur_nxt[w_s]   = PW'(1);
                          w_pc_nxt[w_s]    = NCS;
                      end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NPROC; i++) begin
                r_pc[i]  <= NCS;
                r_cur[i] <= PW'(1);
            end
            r_level   <= '0;
            r_victim  <= '0;
            r_in_cs   <= '0;
            r_waiting <= '0;
        end else begin
            r_pc     <= w_pc_nxt;
            r_cur    <= w_cur_nxt;
            r_level  <= w_level_nxt;
            r_victim <= w_victim_nxt;
            for (int i = 0; i < NPROC; i++) begin
                r_in_cs[i]   <= (w_pc_nxt[i] == CS);
                r_waiting[i] <= (w_pc_nxt[i] == WAIT);
            end
        end
    end

    assign bus.in_cs   = r_in_cs;
    assign bus.waiting = r_waiting;

`ifdef PETERSON_MUTEX_CHECK_EN
    logic r_mutex_err;

    always_ff @(posedge clock) begin
        if (reset) r_mutex_err <= 1'b0;
        else       r_mutex_err <= r_mutex_err | (popcount(32'(r_in_cs)) > 32'd1);
    end

    assign bus.mutex_err = r_mutex_err;
`else
    assign bus.mutex_err = 1'b0;
`endif
endmodule

// File: tb/tb_peterson_filter.sv
// Bench for peterson_filter: NPROC=4 instance checked against a behavioural model via a
// scoreboard, plus an NPROC=5 instance where out-of-range selects are representable.
module tb_peterson_filter;
    import peterson_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    peterson_filter_if #(.NPROC(4)) bif ();
    peterson_filter_if #(.NPROC(5)) bif5 ();

    peterson_filter #(.NPROC(4)) dut  (.clock(clk), .reset(rst), .bus(bif));
    peterson_filter #(.NPROC(5)) dut5 (.clock(clk), .reset(rst), .bus(bif5));

    int n_tests = 0;
    int n_fail  = 0;
    logic [8:0] sb_q[$];   // {in_cs[3:0], waiting[3:0], mutex_err}

    loc_t m_pc[4];
    int   m_cur[4], m_level[4], m_victim[4];

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_pc[i] = NCS; m_cur[i] = 1; m_level[i] = 0; m_victim[i] = 0;
        end
    endtask

    task automatic model_step(input int s, input bit pz);
        bit oth, blk;
        int c;
        if (s >= 4) return;
        c = m_cur[s];
        oth = 1'b0;
        for (int k = 0; k < 4; k++) if (k != s && m_level[k] >= c) oth = 1'b1;
        blk = (m_victim[c] == s) && oth;
        case (m_pc[s])
            NCS:  if (!pz) begin m_pc[s] = LVL; m_cur[s] = 1; end
            LVL:  begin m_level[s] = c; m_pc[s] = VIC; end
            VIC:  begin m_victim[c] = s; m_pc[s] = WAIT; end
            WAIT: if (!blk) begin
                      if (c == 3) m_pc[s] = CS;
                      else begin m_cur[s] = c + 1; m_pc[s] = LVL; end
                  end
            CS:   if (!pz) m_pc[s] = EXIT;
            EXIT: begin m_level[s] = 0; m_cur[s] = 1; m_pc[s] = NCS; end
            default: ;
        endcase
    endtask

    function automatic logic [8:0] model_out();
        logic [3:0] cs, wt;
        for (int i = 0; i < 4; i++) begin
            cs[i] = (m_pc[i] == CS);
            wt[i] = (m_pc[i] == WAIT);
        end
        return {cs, wt, 1'b0};
    endfunction

    task automatic step(input int s, input bit pz);
        bif.select = 2'(s);
        bif.pause  = pz;
        @(posedge clk);
        model_step(s, pz);
        sb_q.push_back(model_out());
        #1;
    endtask

    task automatic step5(input int s, input bit pz);
        bif5.select = 3'(s);
        bif5.pause  = pz;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        model_reset();
        sb_q.push_back(9'd0);
        #1;
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        logic [8:0] e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_tests++;
            if ({bif.in_cs, bif.waiting, bif.mutex_err} !== e) begin
                n_fail++;
                $display("FAIL scoreboard t=%0t got cs=%b wt=%b err=%b exp cs=%b wt=%b err=%b",
                         $time, bif.in_cs, bif.waiting, bif.mutex_err, e[8:5], e[4:1], e[0]);
            end
            n_tests++;
            if ($countones(bif.in_cs) > 1) begin
                n_fail++;
                $display("FAIL mutex_prop t=%0t got in_cs=%b exp at most one bit", $time, bif.in_cs);
            end
        end
    end

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (dut.r_pc[i] !== NCS || dut.r_cur[i] !== 2'd1 || dut.r_level[i] !== 2'd0) begin
                n_fail++;
                $display("FAIL reset_state p%0d got pc=%0d cur=%0d lvl=%0d exp 0 1 0",
                         i, dut.r_pc[i], dut.r_cur[i], dut.r_level[i]);
            end
        end
        n_tests++;
        if (dut.r_victim !== 8'd0) begin
            n_fail++; $display("FAIL reset_victim got %h exp 0", dut.r_victim);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        step(0, 0); step(0, 0);
        n_tests++;
        if (dut.r_pc[0] !== VIC || dut.r_level[0] !== 2'd1) begin
            n_fail++;
            $display("FAIL mid_vic got pc=%0d lvl=%0d exp %0d 1", dut.r_pc[0], dut.r_level[0], VIC);
        end
        step(0, 0);
        do_reset();
        n_tests++;
        if (dut.r_pc[0] !== NCS || dut.r_level[0] !== 2'd0 || dut.r_cur[0] !== 2'd1) begin
            n_fail++;
            $display("FAIL mid_reset got pc=%0d lvl=%0d cur=%0d exp 0 0 1",
                     dut.r_pc[0], dut.r_level[0], dut.r_cur[0]);
        end
    endtask

    task automatic test_solo();
        do_reset();
        repeat (9) step(2, 0);
        n_tests++;
        if (dut.r_pc[2] !== WAIT || dut.r_cur[2] !== 2'd3 || bif.in_cs !== 4'b0000) begin
            n_fail++;
            $display("FAIL solo_pre got pc=%0d cur=%0d cs=%b exp %0d 3 0000",
                     dut.r_pc[2], dut.r_cur[2], bif.in_cs, WAIT);
        end
        step(2, 0);
        n_tests++;
        if (bif.in_cs !== 4'b0100) begin
            n_fail++; $display("FAIL solo_cs got %b exp 0100", bif.in_cs);
        end
        step(2, 0); step(2, 0);
        n_tests++;
        if (dut.r_pc[2] !== NCS || dut.r_level[2] !== 2'd0) begin
            n_fail++;
            $display("FAIL solo_exit got pc=%0d lvl=%0d exp 0 0", dut.r_pc[2], dut.r_level[2]);
        end
    endtask

    task automatic test_contention();
        do_reset();
        for (int i = 0; i < 6; i++) step(i % 2, 0);
        step(1, 0);
        n_tests++;
        if (bif.waiting !== 4'b0011 || dut.r_victim[1] !== 2'd1) begin
            n_fail++;
            $display("FAIL cont_wait got wt=%b vic1=%0d exp 0011 1", bif.waiting, dut.r_victim[1]);
        end
        for (int i = 0; i < 7; i++) begin step(0, 0); step(1, 0); end
        n_tests++;
        if (bif.in_cs !== 4'b0001 || dut.r_pc[1] !== WAIT) begin
            n_fail++;
            $display("FAIL cont_p0cs got cs=%b pc1=%0d exp 0001 %0d", bif.in_cs, dut.r_pc[1], WAIT);
        end
        step(0, 0); step(1, 0);
        n_tests++;
        if (dut.r_pc[1] !== WAIT) begin
            n_fail++; $display("FAIL cont_exit_hold got pc1=%0d exp %0d", dut.r_pc[1], WAIT);
        end
        step(0, 0);
        repeat (7) step(1, 0);
        n_tests++;
        if (bif.in_cs !== 4'b0010) begin
            n_fail++; $display("FAIL cont_p1cs got %b exp 0010", bif.in_cs);
        end
    endtask

    task automatic test_pause();
        do_reset();
        repeat (10) step(3, 0);
        repeat (3) step(0, 0);
        repeat (3) step(1, 0);
        repeat (20) step(3, 1);
        n_tests++;
        if (bif.in_cs !== 4'b1000 || dut.r_pc[3] !== CS) begin
            n_fail++; $display("FAIL pause_hold got cs=%b pc3=%0d exp 1000 %0d", bif.in_cs, dut.r_pc[3], CS);
        end
        for (int i = 0; i < 4; i++) begin step(0, 0); step(1, 0); end
        n_tests++;
        if (bif.waiting !== 4'b0011 || bif.in_cs !== 4'b1000 || dut.r_cur[0] !== 2'd2) begin
            n_fail++;
            $display("FAIL pause_stall got wt=%b cs=%b cur0=%0d exp 0011 1000 2",
                     bif.waiting, bif.in_cs, dut.r_cur[0]);
        end
        step(3, 0);
        n_tests++;
        if (dut.r_pc[3] !== EXIT) begin
            n_fail++; $display("FAIL pause_release got pc3=%0d exp %0d", dut.r_pc[3], EXIT);
        end
    endtask

    task automatic test_stutter();
        bif.select = 2'd0;
        bif.pause  = 1'b1;
        do_reset();
        repeat (4) step5(0, 0);
        step5(1, 0);
        n_tests++;
        if (dut5.r_pc[0] !== LVL || dut5.r_cur[0] !== 3'd2 || dut5.r_level[0] !== 3'd1) begin
            n_fail++;
            $display("FAIL stut_pre got pc=%0d cur=%0d lvl=%0d exp %0d 2 1",
                     dut5.r_pc[0], dut5.r_cur[0], dut5.r_level[0], LVL);
        end
        for (int i = 0; i < 8; i++) step5(5 + (i % 3), i[0]);
        n_tests++;
        if (dut5.r_pc[0] !== LVL || dut5.r_cur[0] !== 3'd2 || dut5.r_level[0] !== 3'd1 ||
            dut5.r_pc[1] !== LVL || dut5.r_victim[1] !== 3'd0 ||
            bif5.in_cs !== 5'd0 || bif5.waiting !== 5'd0) begin
            n_fail++;
            $display("FAIL stut_hold got pc0=%0d cur0=%0d lvl0=%0d pc1=%0d vic1=%0d cs=%b wt=%b exp %0d 2 1 %0d 0 0 0",
                     dut5.r_pc[0], dut5.r_cur[0], dut5.r_level[0], dut5.r_pc[1],
                     dut5.r_victim[1], bif5.in_cs, bif5.waiting, LVL, LVL);
        end
        step5(0, 0);
        n_tests++;
        if (dut5.r_pc[0] !== VIC || dut5.r_level[0] !== 3'd2) begin
            n_fail++;
            $display("FAIL stut_resume got pc=%0d lvl=%0d exp %0d 2", dut5.r_pc[0], dut5.r_level[0], VIC);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 10000; i++)
            step(int'($urandom_range(0, 3)), $urandom_range(0, 3) == 0);
    endtask

`ifdef PETERSON_MUTEX_CHECK_EN
    task automatic test_mutex_force();
        loc_t [3:0] fv;
        @(negedge clk);
        bif.select = 2'd0;
        bif.pause  = 1'b1;
        for (int i = 0; i < 4; i++) fv[i] = NCS;
        fv[0] = CS;
        fv[1] = CS;
        force dut.r_pc = fv;
        @(posedge clk); #1;
        n_tests++;
        if (bif.in_cs !== 4'b0011 || bif.mutex_err !== 1'b0) begin
            n_fail++; $display("FAIL force_cs got cs=%b err=%b exp 0011 0", bif.in_cs, bif.mutex_err);
        end
        @(posedge clk); #1;
        n_tests++;
        if (bif.mutex_err !== 1'b1) begin
            n_fail++; $display("FAIL force_err got %b exp 1", bif.mutex_err);
        end
        release dut.r_pc;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (bif.mutex_err !== 1'b1) begin
            n_fail++; $display("FAIL err_sticky got %b exp 1", bif.mutex_err);
        end
        do_reset();
        n_tests++;
        if (bif.mutex_err !== 1'b0) begin
            n_fail++; $display("FAIL err_reset got %b exp 0", bif.mutex_err);
        end
    endtask
`endif

    initial begin
        bif.select  = '0;
        bif.pause   = 1'b1;
        bif5.select = '0;
        bif5.pause  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_reset_mid();
        test_solo();
        test_contention();
        test_pause();
        test_stutter();
        test_random();
`ifdef PETERSON_MUTEX_CHECK_EN
        test_mutex_force();
`endif
        repeat (3) @(posedge clk);
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++; $display("FAIL sb_drain got %0d left exp 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
